multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control FSM for the multi-cycle MIPS datapath; replaces single-cycle opcode decode with a state-sequenced control unit. Sequences fetch/decode/execute/memory/writeback over shared PC, IR, ALU and unified memory. Honours a memory ready handshake so slow memory stalls the sequence without corrupting architectural state.

Parameters:
MEM_WAIT, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
OPC  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
PCWrite  out  1  PC load enable
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load enable
RegWrite  out  1  register file write enable
ALUsrcA  out  1  0 = PC, 1 = A reg
ALUsrcB  out  2  00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
RegDst  out  2  00 = rt, 01 = rd, 10 = $31
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
PCsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = A reg
ALUoperation  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
instr_done  out  1  pulse in last cycle of each instruction
illegal  out  1  pulse in DECODE on unsupported OPC/func

Behaviour:
- Moore FSM, one state register. Outputs combinational from state; PCWrite, IRWrite, MemWrite and RegWrite are additionally qualified by zero/mem_ready where noted.
- Reset: rst=0 at an edge -> state=FETCH. While rst=0, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, instr_done and illegal are forced 0. Reset mid-instruction abandons it with no further writes.
- Supported: R-type (add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000), lw 100011, sw 101011, addi 001000, slti 001010, beq 000100, bne 000101, j 000010, jal 000011.
- FETCH: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, add, PCsrc=00. Stays in FETCH with IRWrite=PCWrite=0 while mem_ready=0. On mem_ready=1, IRWrite=1, PCWrite=1 and state goes to DECODE.
- DECODE: ALUsrcA=0, ALUsrcB=11, add (branch target into ALUOut). Next state by OPC: lw/sw->MEMADR; R-type->JR if func=001000, else RTYPEEX; addi/slti->IMMEX; beq/bne->BRANCH; j->JUMP; jal->JAL. Anything else: illegal=1, instr_done=1, next FETCH.
- MEMADR: ALUsrcA=1, ALUsrcB=10, add. lw->MEMRD, sw->MEMWR.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, RegDst=00, MemtoReg=01, instr_done.
- MEMWR: MemWrite=1, IorD=1 while waiting. Holds until mem_ready; instr_done in the mem_ready cycle, then FETCH. The write is accepted exactly once, in the mem_ready cycle.
- RTYPEEX: ALUsrcA=1, ALUsrcB=00, ALUoperation from func; then RTYPEWB.
- RTYPEWB: RegWrite=1, RegDst=01, MemtoReg=00, instr_done.
- IMMEX: ALUsrcA=1, ALUsrcB=10, add (addi) or slt (slti); then IMMWB.
- IMMWB: RegWrite=1, RegDst=00, MemtoReg=00, instr_done.
- BRANCH: ALUsrcA=1, ALUsrcB=00, sub, PCsrc=01. PCWrite=zero for beq and ~zero for bne. instr_done.
- JUMP: PCsrc=10, PCWrite=1, instr_done.
- JAL: PCsrc=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10 (PC already holds PC+4), instr_done.
- JR: PCsrc=11, PCWrite=1, instr_done.
- Every *WB/BRANCH/JUMP/JAL/JR state returns to FETCH.
- Latency with zero wait: beq/bne/j/jal/jr 3 cycles, R/addi/slti/sw 4, lw 5. Each wait cycle adds 1.
- Unused outputs default 0 in every state.

Decomposition:
- Package mc_pkg holds:
  - state enum: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, JR
  - opcode and func constants
  - ALUoperation codes
  - ALUsrcB/RegDst/MemtoReg/PCsrc selector constants
- One sub-module, mc_alu_decode: combinational; (2-bit aluop: add/sub/func/slt, func) -> ALUoperation.

Test Plan:
- Reset: rst=0 for 2 cycles, mem_ready=1 -> all enables 0; after release FETCH, MemRead=1; first mem_ready edge gives IRWrite=PCWrite=1.
- add (OPC 000000, func 100000), mem_ready=1 -> 4 cycles; RegWrite=1, RegDst=01 in cycle 4, ALUoperation=010 in cycle 3; instr_done once.
- lw with mem_ready low 2 cycles in MEMRD -> 7 cycles total; MemRead/IorD=1 held for 3 cycles; RegWrite only in MEMWB with MemtoReg=01.
- beq zero=1 -> PCWrite=1, PCsrc=01 in cycle 3; beq zero=0 -> PCWrite=0; bne inverse.
- jal -> cycle 3 PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10; jr (func 001000) -> PCsrc=11 in cycle 3.
- OPC 111111 -> illegal=1 and instr_done=1 in DECODE, no writes, back to FETCH; rst=0 asserted during MEMWR wait -> MemWrite never asserted with mem_ready, state FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcode/func
// values, ALU operation codes and datapath mux selector values.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
    RTYPEWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Coarse ALU intent from the FSM, refined by mc_alu_decode.
  localparam logic [1:0] AOP_ADD  = 2'b00;
  localparam logic [1:0] AOP_SUB  = 2'b01;
  localparam logic [1:0] AOP_FUNC = 2'b10;
  localparam logic [1:0] AOP_SLT  = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  // R-type func codes that take the RTYPEEX/RTYPEWB path (jr is routed separately).
  function automatic logic rtype_alu_func(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Maps the FSM's coarse ALU request plus the R-type func field to the
// 3-bit ALU operation code.
module mc_alu_decode
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] func,
  output logic [2:0] alu_operation
);

  always_comb begin
    alu_operation = ALU_ADD;
    case (aluop)
      AOP_ADD: alu_operation = ALU_ADD;
      AOP_SUB: alu_operation = ALU_SUB;
      AOP_SLT: alu_operation = ALU_SLT;
      default: begin
        case (func)
          FN_SUB:  alu_operation = ALU_SUB;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_SLT:  alu_operation = ALU_SLT;
          default: alu_operation = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath; memory states stall on
// mem_ready so a slow memory never causes a duplicated or lost write.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OPC,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUsrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] PCsrc,
  output logic [2:0] ALUoperation,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, state_next;
  logic       ready;
  logic       pc_write, mem_read, mem_write, ir_write, reg_write, done, bad_op;
  logic       alu_use;
  logic [1:0] aluop;
  logic [2:0] alu_code;

  assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    done       = 1'b0;
    bad_op     = 1'b0;
    alu_use    = 1'b0;
    aluop      = AOP_ADD;
    IorD       = 1'b0;
    ALUsrcA    = 1'b0;
    ALUsrcB    = SRCB_B;
    RegDst     = DST_RT;
    MemtoReg   = M2R_ALUOUT;
    PCsrc      = PCSRC_ALU;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        alu_use  = 1'b1;
        ALUsrcB  = SRCB_FOUR;
        ir_write = ready;
        pc_write = ready;
        if (ready) state_next = DECODE;
      end
      DECODE: begin
        alu_use = 1'b1;
        ALUsrcB = SRCB_IMMSH;
        case (OPC)
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_ADDI, OP_SLTI: state_next = IMMEX;
          OP_BEQ, OP_BNE:   state_next = BRANCH;
          OP_J:             state_next = JUMP;
          OP_JAL:           state_next = JAL;
          OP_RTYPE: begin
            if (func == FN_JR)              state_next = JR;
            else if (rtype_alu_func(func)) state_next = RTYPEEX;
            else begin
              bad_op     = 1'b1;
              done       = 1'b1;
              state_next = FETCH;
            end
          end
          default: begin
            bad_op     = 1'b1;
            done       = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_use    = 1'b1;
        ALUsrcA    = 1'b1;
        ALUsrcB    = SRCB_IMM;
        state_next = (OPC == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
        if (ready) state_next = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        MemtoReg   = M2R_MDR;
        done       = 1'b1;
        state_next = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        done      = ready;
        if (ready) state_next = FETCH;
      end
      RTYPEEX: begin
        alu_use    = 1'b1;
        ALUsrcA    = 1'b1;
        aluop      = AOP_FUNC;
        state_next = RTYPEWB;
      end
      RTYPEWB: begin
        reg_write  = 1'b1;
        RegDst     = DST_RD;
        done       = 1'b1;
        state_next = FETCH;
      end
      IMMEX: begin
        alu_use    = 1'b1;
        ALUsrcA    = 1'b1;
        ALUsrcB    = SRCB_IMM;
        aluop      = (OPC == OP_SLTI) ? AOP_SLT : AOP_ADD;
        state_next = IMMWB;
      end
      IMMWB: begin
        reg_write  = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_use    = 1'b1;
        ALUsrcA    = 1'b1;
        aluop      = AOP_SUB;
        PCsrc      = PCSRC_ALUOUT;
        pc_write   = (OPC == OP_BNE) ? ~zero : zero;
        done       = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        PCsrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        PCsrc      = PCSRC_JUMP;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        RegDst     = DST_RA;
        MemtoReg   = M2R_PC;
        done       = 1'b1;
        state_next = FETCH;
      end
      JR: begin
        PCsrc      = PCSRC_REG;
        pc_write   = 1'b1;
        done       = 1'b1;
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  mc_alu_decode u_alu_decode (
    .aluop         (aluop),
    .func          (func),
    .alu_operation (alu_code)
  );

  assign ALUoperation = alu_use ? alu_code : 3'b000;

  // Reset suppresses every state-changing strobe, including mid-instruction.
  assign PCWrite    = rst & pc_write;
  assign MemRead    = rst & mem_read;
  assign MemWrite   = rst & mem_write;
  assign IRWrite    = rst & ir_write;
  assign RegWrite   = rst & reg_write;
  assign instr_done = rst & done;
  assign illegal    = rst & bad_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: each step drives inputs on the
// falling edge and compares the full control word against a hand-written value.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OPC, func;
  logic       zero, mem_ready;
  logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUsrcA;
  logic [1:0] ALUsrcB, RegDst, MemtoReg, PCsrc;
  logic [2:0] ALUoperation;
  logic       instr_done, illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .OPC(OPC), .func(func), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .PCsrc(PCsrc), .ALUoperation(ALUoperation),
    .instr_done(instr_done), .illegal(illegal)
  );

  // Control word layout:
  // PCWrite IorD MemRead MemWrite IRWrite RegWrite ALUsrcA ALUsrcB RegDst MemtoReg PCsrc ALUop done illegal
  function automatic logic [19:0] pk(
    input logic pcw, iord, mrd, mwr, irw, rgw, asa,
    input logic [1:0] asb, rdst, m2r, pcs,
    input logic [2:0] aop,
    input logic dn, il);
    return {pcw, iord, mrd, mwr, irw, rgw, asa, asb, rdst, m2r, pcs, aop, dn, il};
  endfunction

  localparam logic [19:0] V_RST_FETCH = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_FETCH     = pk(1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_FETCH_W   = pk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_DEC       = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_DEC_ILL   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,2'b00,3'b010,1'b1,1'b1);
  localparam logic [19:0] V_REX_ADD   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_REX_SLT   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b111,1'b0,1'b0);
  localparam logic [19:0] V_REX_OR    = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,3'b001,1'b0,1'b0);
  localparam logic [19:0] V_RWB       = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b01,2'b00,2'b00,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_MADR      = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_MRD       = pk(1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0);
  localparam logic [19:0] V_MWB       = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b01,2'b00,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_MWR_W     = pk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0);
  localparam logic [19:0] V_MWR_R     = pk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_MWR_RST   = pk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0);
  localparam logic [19:0] V_IEX_ADD   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,3'b010,1'b0,1'b0);
  localparam logic [19:0] V_IEX_SLT   = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,2'b00,3'b111,1'b0,1'b0);
  localparam logic [19:0] V_IWB       = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_BR_TAKEN  = pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,3'b110,1'b1,1'b0);
  localparam logic [19:0] V_BR_NOT    = pk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b01,3'b110,1'b1,1'b0);
  localparam logic [19:0] V_JUMP      = pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b10,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_JAL       = pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b10,2'b10,2'b10,3'b000,1'b1,1'b0);
  localparam logic [19:0] V_JR        = pk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,2'b11,3'b000,1'b1,1'b0);

  // Drive one cycle's inputs, compare the resulting control word, advance a clock.
  task automatic cyc(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [19:0] exp);
    logic [19:0] obs;
    OPC = opc; func = fn; zero = z; mem_ready = mr;
    #1;
    obs = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUsrcA, ALUsrcB,
           RegDst, MemtoReg, PCsrc, ALUoperation, instr_done, illegal};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; OPC = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cyc("reset", 6'b000000, 6'b100000, 1'b0, 1'b1, V_RST_FETCH);
    rst = 1'b1;

    // add: 4 cycles
    cyc("add.fetch", 6'b000000, 6'b100000, 1'b0, 1'b1, V_FETCH);
    cyc("add.dec",   6'b000000, 6'b100000, 1'b0, 1'b1, V_DEC);
    cyc("add.ex",    6'b000000, 6'b100000, 1'b0, 1'b1, V_REX_ADD);
    cyc("add.wb",    6'b000000, 6'b100000, 1'b0, 1'b1, V_RWB);

    // lw with two wait cycles in MEMRD: 7 cycles
    cyc("lw.fetch",  6'b100011, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("lw.dec",    6'b100011, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("lw.adr",    6'b100011, 6'b000000, 1'b0, 1'b1, V_MADR);
    cyc("lw.rd0",    6'b100011, 6'b000000, 1'b0, 1'b0, V_MRD);
    cyc("lw.rd1",    6'b100011, 6'b000000, 1'b0, 1'b0, V_MRD);
    cyc("lw.rd2",    6'b100011, 6'b000000, 1'b0, 1'b1, V_MRD);
    cyc("lw.wb",     6'b100011, 6'b000000, 1'b0, 1'b1, V_MWB);

    // sw with a fetch wait and a write wait
    cyc("sw.fetchw", 6'b101011, 6'b000000, 1'b0, 1'b0, V_FETCH_W);
    cyc("sw.fetch",  6'b101011, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("sw.dec",    6'b101011, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("sw.adr",    6'b101011, 6'b000000, 1'b0, 1'b1, V_MADR);
    cyc("sw.wrw",    6'b101011, 6'b000000, 1'b0, 1'b0, V_MWR_W);
    cyc("sw.wr",     6'b101011, 6'b000000, 1'b0, 1'b1, V_MWR_R);

    // beq / bne, both zero polarities
    cyc("beq1.fetch", 6'b000100, 6'b000000, 1'b1, 1'b1, V_FETCH);
    cyc("beq1.dec",   6'b000100, 6'b000000, 1'b1, 1'b1, V_DEC);
    cyc("beq1.br",    6'b000100, 6'b000000, 1'b1, 1'b1, V_BR_TAKEN);
    cyc("beq0.fetch", 6'b000100, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("beq0.dec",   6'b000100, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("beq0.br",    6'b000100, 6'b000000, 1'b0, 1'b1, V_BR_NOT);
    cyc("bne0.fetch", 6'b000101, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("bne0.dec",   6'b000101, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("bne0.br",    6'b000101, 6'b000000, 1'b0, 1'b1, V_BR_TAKEN);
    cyc("bne1.fetch", 6'b000101, 6'b000000, 1'b1, 1'b1, V_FETCH);
    cyc("bne1.dec",   6'b000101, 6'b000000, 1'b1, 1'b1, V_DEC);
    cyc("bne1.br",    6'b000101, 6'b000000, 1'b1, 1'b1, V_BR_NOT);

    // jumps
    cyc("jal.fetch", 6'b000011, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("jal.dec",   6'b000011, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("jal.ex",    6'b000011, 6'b000000, 1'b0, 1'b1, V_JAL);
    cyc("jr.fetch",  6'b000000, 6'b001000, 1'b0, 1'b1, V_FETCH);
    cyc("jr.dec",    6'b000000, 6'b001000, 1'b0, 1'b1, V_DEC);
    cyc("jr.ex",     6'b000000, 6'b001000, 1'b0, 1'b1, V_JR);
    cyc("j.fetch",   6'b000010, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("j.dec",     6'b000010, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("j.ex",      6'b000010, 6'b000000, 1'b0, 1'b1, V_JUMP);

    // other ALU selections
    cyc("slt.fetch",  6'b000000, 6'b101010, 1'b0, 1'b1, V_FETCH);
    cyc("slt.dec",    6'b000000, 6'b101010, 1'b0, 1'b1, V_DEC);
    cyc("slt.ex",     6'b000000, 6'b101010, 1'b0, 1'b1, V_REX_SLT);
    cyc("slt.wb",     6'b000000, 6'b101010, 1'b0, 1'b1, V_RWB);
    cyc("or.fetch",   6'b000000, 6'b100101, 1'b0, 1'b1, V_FETCH);
    cyc("or.dec",     6'b000000, 6'b100101, 1'b0, 1'b1, V_DEC);
    cyc("or.ex",      6'b000000, 6'b100101, 1'b0, 1'b1, V_REX_OR);
    cyc("or.wb",      6'b000000, 6'b100101, 1'b0, 1'b1, V_RWB);
    cyc("addi.fetch", 6'b001000, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("addi.dec",   6'b001000, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("addi.ex",    6'b001000, 6'b000000, 1'b0, 1'b1, V_IEX_ADD);
    cyc("addi.wb",    6'b001000, 6'b000000, 1'b0, 1'b1, V_IWB);
    cyc("slti.fetch", 6'b001010, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("slti.dec",   6'b001010, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("slti.ex",    6'b001010, 6'b000000, 1'b0, 1'b1, V_IEX_SLT);
    cyc("slti.wb",    6'b001010, 6'b000000, 1'b0, 1'b1, V_IWB);

    // illegal opcode and illegal R-type func
    cyc("ill.fetch",  6'b111111, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("ill.dec",    6'b111111, 6'b000000, 1'b0, 1'b1, V_DEC_ILL);
    cyc("illf.fetch", 6'b000000, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("illf.dec",   6'b000000, 6'b000000, 1'b0, 1'b1, V_DEC_ILL);

    // reset during a stalled store
    cyc("swr.fetch", 6'b101011, 6'b000000, 1'b0, 1'b1, V_FETCH);
    cyc("swr.dec",   6'b101011, 6'b000000, 1'b0, 1'b1, V_DEC);
    cyc("swr.adr",   6'b101011, 6'b000000, 1'b0, 1'b1, V_MADR);
    cyc("swr.wrw",   6'b101011, 6'b000000, 1'b0, 1'b0, V_MWR_W);
    rst = 1'b0;
    cyc("swr.rst",   6'b101011, 6'b000000, 1'b0, 1'b1, V_MWR_RST);
    rst = 1'b1;
    cyc("swr.after", 6'b101011, 6'b000000, 1'b0, 1'b1, V_FETCH);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
